// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline hazard controller (load-use stall, EX branch flush, mul/div hold-in-ID)
// Ports: clk, rstn (sync active-low); id_rs1/id_rs2/id_uses_rs1/id_uses_rs2/id_md_valid from ID;
//   ex_rd/ex_memread/ex_branch_taken from EX; ctrl_select/pc_write/if_id_write/if_id_flush to the
//   pipeline registers; md_busy while a mul/div is held; stall_cycles saturating debug counter.
// Build option: HAZARD_CTRL_MULDIV_EN enables the MD_WAIT/MD_ISSUE sequencing and the latency counter.
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_md_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    output logic        ctrl_select,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        md_busy,
    output logic [15:0] stall_cycles
);
    logic load_use;
    logic stall;

    assign load_use = ex_memread & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

`ifdef HAZARD_CTRL_MULDIV_EN
    typedef enum logic [1:0] {RUN, MD_WAIT, MD_ISSUE} state_t;
    localparam logic [3:0] LAT_M1 = 4'(MD_LAT - 1);
    state_t     state;
    logic [3:0] cnt;

    // A taken branch overrides every hold; MD_ISSUE passes so the held op is not re-triggered.
    assign stall   = ~ex_branch_taken &
                     (((state == RUN) & (load_use | id_md_valid)) | (state == MD_WAIT));
    assign md_busy = state == MD_WAIT;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else if (ex_branch_taken) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    // load-use takes precedence: a dependent mul/div enters only after the load stall
                    if (!load_use && id_md_valid) begin
                        state <= MD_WAIT;
                        cnt   <= LAT_M1;
                    end
                end
                MD_WAIT: begin
                    if (cnt == 4'd1) state <= MD_ISSUE;
                    else cnt <= cnt - 4'd1;
                end
                default: state <= RUN;
            endcase
        end
    end
`else
    logic [4:0] unused_md;

    assign unused_md = {id_md_valid, 4'(MD_LAT)};
    assign stall     = ~ex_branch_taken & load_use;
    assign md_busy   = 1'b0;
`endif

    assign ctrl_select = ~stall & ~ex_branch_taken;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign if_id_flush = ex_branch_taken;

    always_ff @(posedge clk) begin
        if (!rstn) stall_cycles <= 16'd0;
        else if (!pc_write && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int LAT = 4;
    // expected output code {ctrl_select, pc_write, if_id_write, if_id_flush, md_busy}
    localparam logic [4:0] P = 5'b11100, S = 5'b00000, F = 5'b01110, W = 5'b00001;

    typedef struct packed {
        logic [4:0]  o;
        logic [15:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_md_valid, ex_memread, ex_branch_taken;
    logic        ctrl_select, pc_write, if_id_write, if_id_flush, md_busy;
    logic [15:0] stall_cycles;

    exp_t        q[$];
    logic [15:0] sc;
    int          n_vec = 0;
    int          n_err = 0;

    hazard_ctrl #(.MD_LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_md_valid(id_md_valid),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .ctrl_select(ctrl_select), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("outs", {ctrl_select, pc_write, if_id_write, if_id_flush, md_busy}, e.o);
            check("stall_cycles", stall_cycles, e.sc);
        end
    end

    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic md, input logic [4:0] rd, input logic mr, input logic bt,
                       input logic [4:0] e, input bit chk);
        @(posedge clk);
        #1;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_md_valid = md; ex_rd = rd; ex_memread = mr; ex_branch_taken = bt;
        if (chk) q.push_back('{o: e, sc: sc});
        if (!e[3] && sc != 16'hFFFF) sc = sc + 16'd1;
    endtask

    initial begin
        rstn = 1'b0;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_uses_rs1, id_uses_rs2, id_md_valid, ex_memread, ex_branch_taken} = '0;
        sc = 16'd0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
        cyc(5, 0, 1, 0, 0, 5, 1, 0, S, 1);
        cyc(5, 0, 1, 0, 0, 5, 0, 0, P, 1);
        cyc(0, 7, 0, 1, 0, 7, 1, 0, S, 1);
        cyc(7, 0, 0, 1, 0, 7, 1, 0, P, 1);
        cyc(0, 0, 1, 1, 0, 0, 1, 0, P, 1);
        cyc(5, 0, 1, 0, 0, 5, 1, 1, F, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
`ifdef HAZARD_CTRL_MULDIV_EN
        cyc(1, 2, 1, 1, 1, 0, 0, 0, S, 1);
        for (int i = 1; i < LAT; i++) cyc(1, 2, 1, 1, 1, 0, 0, 0, W, 1);
        cyc(1, 2, 1, 1, 1, 0, 0, 0, P, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
        cyc(1, 2, 1, 1, 1, 0, 0, 0, S, 1);
        cyc(1, 2, 1, 1, 1, 0, 0, 0, W, 1);
        cyc(1, 2, 1, 1, 1, 0, 0, 1, F | W, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
        cyc(3, 0, 1, 0, 1, 3, 1, 0, S, 1);
        cyc(3, 0, 1, 0, 1, 3, 0, 0, S, 1);
        for (int i = 1; i < LAT; i++) cyc(3, 0, 1, 0, 1, 3, 0, 0, W, 1);
        cyc(3, 0, 1, 0, 1, 3, 0, 0, P, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
`else
        cyc(1, 2, 1, 1, 1, 0, 0, 0, P, 1);
        cyc(3, 0, 1, 0, 1, 3, 1, 0, S, 1);
        cyc(3, 0, 1, 0, 1, 3, 0, 0, P, 1);
        cyc(1, 2, 1, 1, 1, 0, 0, 1, F, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
`endif
        for (int i = 0; i < 65600; i++) cyc(9, 0, 1, 0, 0, 9, 1, 0, S, 0);
        cyc(9, 0, 1, 0, 0, 9, 1, 0, S, 1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        {id_uses_rs1, ex_memread} = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sc = 16'd0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
        cyc(5, 0, 1, 0, 0, 5, 1, 0, S, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, P, 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
